// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the single-cycle core and its instruction memory
//   controller: memory geometry, opcode encodings, and the imem_ctrl state
//   enum. No ports.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W  = 8;   // 256-word instruction memory
    localparam int INSTR_W = 16;  // two loader bytes per word

    typedef enum logic [3:0] {
        OP_JMP   = 4'b0000,
        OP_LOAD  = 4'b0001,
        OP_STORE = 4'b0010,
        OP_ADD   = 4'b0011,
        OP_SUB   = 4'b0100,
        OP_ADDI  = 4'b0101,
        OP_HALT  = 4'b0110,
        OP_AND   = 4'b0111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_WRITE,
        ST_PC_CLR,
        ST_RUN,
        ST_HALTED
    } imem_state_e;

    // A length of 0 stands for a full memory image, so the word count
    // needs one bit more than the length field.
    function automatic logic [ADDR_W:0] load_count(input logic [ADDR_W-1:0] len);
        return (len == '0) ? (ADDR_W + 1)'(1 << ADDR_W) : {1'b0, len};
    endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_ctrl_if
//   Groups the loader byte stream and the instruction memory write port.
//   master : host / loader side (drives the byte stream, observes writes)
//   slave  : imem_ctrl side (accepts bytes, drives the write port)
//   rx_data/rx_valid/rx_ready   byte stream, high byte of each word first
//   mem_we/mem_waddr/mem_wdata  instruction memory write port
// ---------------------------------------------------------------------------
interface imem_ctrl_if;
    import cpu_pkg::*;

    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [INSTR_W-1:0] mem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_waddr, mem_wdata
    );

endinterface

// File: rtl/imem_ctrl.sv
// ---------------------------------------------------------------------------
// imem_ctrl
//   Loads a program image into the 256 x 16 instruction memory from a byte
//   stream, then starts the core, gates its PC advance and stops it on HALT
//   or watchdog expiry.
//
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   load_start   pulse: begin load at load_base for load_len words (0 = 256)
//   bus          imem_ctrl_if.slave: byte stream in, memory write port out
//   run_start    pulse: clear the PC and run
//   abort        level: drop any load or run and return to IDLE
//   fetch_instr  instruction currently fetched by the core
//   pc_rst       one-cycle PC clear to the core
//   cpu_en       core commits the current instruction and advances the PC
//   busy         not IDLE and not HALTED
//   halted       last run ended (HALT or watchdog)
//   timeout      last run ended on the watchdog, sticky until next run
//   load_done    one-cycle pulse after the last word of a load is written
//   instr_count  instructions committed in the current or last run
// ---------------------------------------------------------------------------
module imem_ctrl
    import cpu_pkg::*;
#(
    parameter logic [3:0]        HALT_OP    = OP_HALT,
    parameter int                WDOG_W     = 16,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = {WDOG_W{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic [ADDR_W-1:0]   load_base,
    input  logic [ADDR_W-1:0]   load_len,
    imem_ctrl_if.slave          bus,
    input  logic                run_start,
    input  logic                abort,
    input  logic [INSTR_W-1:0]  fetch_instr,
    output logic                pc_rst,
    output logic                cpu_en,
    output logic                busy,
    output logic                halted,
    output logic                timeout,
    output logic                load_done,
    output logic [WDOG_W-1:0]   instr_count
);

    imem_state_e         state_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [ADDR_W:0]     remaining_q;
    logic [7:0]          hi_q;
    logic [7:0]          lo_q;
    logic [WDOG_W-1:0]   instr_count_q;
    logic                halted_q;
    logic                timeout_q;
    logic                load_done_q;

    logic rx_hs;
    logic op_is_halt;
    logic at_limit;

    // Only the opcode field matters for run control.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^fetch_instr[INSTR_W-5:0];

    assign op_is_halt = (fetch_instr[INSTR_W-1 -: 4] == HALT_OP);
    assign at_limit   = (instr_count_q == WDOG_LIMIT);

    // Abort also withholds rx_ready so no byte is consumed by a load that
    // is being thrown away.
    assign bus.rx_ready = !abort &&
                          ((state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO));
    assign rx_hs        = bus.rx_valid && bus.rx_ready;

    assign bus.mem_we    = !abort && (state_q == ST_WRITE);
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = {hi_q, lo_q};

    // cpu_en must react to the instruction fetched in the same cycle, so it
    // cannot be registered: a registered enable would commit the HALT.
    assign cpu_en = !abort && (state_q == ST_RUN) && !op_is_halt && !at_limit;

    assign pc_rst      = (state_q == ST_PC_CLR);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign load_done   = load_done_q;
    assign instr_count = instr_count_q;

    // NOTE: every register here is written with <= so all of them update
    // from the same pre-edge values; a blocking write would let a later
    // statement see the new value and change the logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            waddr_q       <= '0;
            remaining_q   <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            instr_count_q <= '0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            load_done_q <= 1'b0;

            if (abort) begin
                // halted, timeout and instr_count deliberately hold.
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_HALTED: begin
                        // Load wins a same-cycle collision with run.
                        if (load_start) begin
                            waddr_q     <= load_base;
                            remaining_q <= load_count(load_len);
                            halted_q    <= 1'b0;
                            state_q     <= ST_LOAD_HI;
                        end else if (run_start) begin
                            halted_q    <= 1'b0;
                            state_q     <= ST_PC_CLR;
                        end
                    end

                    ST_LOAD_HI: begin
                        if (rx_hs) begin
                            hi_q    <= bus.rx_data;
                            state_q <= ST_LOAD_LO;
                        end
                    end

                    ST_LOAD_LO: begin
                        if (rx_hs) begin
                            lo_q    <= bus.rx_data;
                            state_q <= ST_WRITE;
                        end
                    end

                    ST_WRITE: begin
                        // Address wraps 255 -> 0 by plain overflow.
                        waddr_q     <= waddr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - (ADDR_W + 1)'(1);
                        if (remaining_q == (ADDR_W + 1)'(1)) begin
                            load_done_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            state_q     <= ST_LOAD_HI;
                        end
                    end

                    ST_PC_CLR: begin
                        instr_count_q <= '0;
                        timeout_q     <= 1'b0;
                        state_q       <= ST_RUN;
                    end

                    ST_RUN: begin
                        if (cpu_en) begin
                            instr_count_q <= instr_count_q + WDOG_W'(1);
                        end
                        // Watchdog takes precedence for the timeout flag
                        // when HALT arrives on the limit cycle.
                        if (op_is_halt || at_limit) begin
                            halted_q <= 1'b1;
                            timeout_q <= at_limit;
                            state_q  <= ST_HALTED;
                        end
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_ctrl
//   Self-checking bench for imem_ctrl. Loads push expected memory writes into
//   a scoreboard queue; a monitor pops and compares on every mem_we and
//   tracks load_done, pc_rst and cpu_en. Runs are checked against a simple
//   model: committed = min(non-HALT prefix length, watchdog limit).
// ---------------------------------------------------------------------------
module tb_imem_ctrl;
    import cpu_pkg::*;

    localparam logic [15:0] LIMIT = 16'd10;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        bit          last;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  load_base;
    logic [7:0]  load_len;
    logic        run_start;
    logic        abort;
    logic [15:0] fetch_instr;
    logic        pc_rst;
    logic        cpu_en;
    logic        busy;
    logic        halted;
    logic        timeout;
    logic        load_done;
    logic [15:0] instr_count;

    imem_ctrl_if bus ();

    imem_ctrl #(.WDOG_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_len    (load_len),
        .bus         (bus),
        .run_start   (run_start),
        .abort       (abort),
        .fetch_instr (fetch_instr),
        .pc_rst      (pc_rst),
        .cpu_en      (cpu_en),
        .busy        (busy),
        .halted      (halted),
        .timeout     (timeout),
        .load_done   (load_done),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];
    bit  done_pending = 1'b0;
    int  cpu_en_cnt = 0;
    int  pc_rst_cnt = 0;
    logic [15:0] fixed_words [3] = '{16'h5005, 16'h510A, 16'h6000};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {16'h0, bus.rx_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata,
                pc_rst, cpu_en, busy, halted, timeout, load_done, instr_count};
    endfunction

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst) begin
            wr_t e;
            if (bus.mem_we || bus.rx_ready || cpu_en)
                check("we_ready_en_exclusive",
                      $countones({bus.mem_we, bus.rx_ready, cpu_en}), 1);
            if (load_done || done_pending)
                check("load_done_timing", load_done, done_pending);
            done_pending = 1'b0;
            if (bus.mem_we) begin
                check("write_was_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("mem_waddr", bus.mem_waddr, e.addr);
                    check("mem_wdata", bus.mem_wdata, e.data);
                    done_pending = e.last;
                end
            end
            if (cpu_en) cpu_en_cnt++;
            if (pc_rst) pc_rst_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit ok = 1'b0;
        if (stall) begin
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rx_ready;
            tick();
        end
        bus.rx_valid = 1'b0;
        check("rx_handshake_in_time", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        check("returned_to_idle", ok, 1);
        tick();
    endtask

    task automatic do_load(input logic [7:0] base, input logic [7:0] len,
                           input bit fixed, input bit stall, input int abort_word,
                           input bit start_collide, input bit run_collide);
        int          nwords;
        int          pc0;
        logic [15:0] w;
        wr_t         e;
        nwords = (len == 8'd0) ? 256 : int'(len);
        pc0 = pc_rst_cnt;
        load_base  = base;
        load_len   = len;
        load_start = 1'b1;
        run_start  = start_collide;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            w = fixed ? fixed_words[i] : 16'($urandom);
            if (i == abort_word) begin
                send_byte(w[15:8], stall);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                break;
            end
            e.addr = base + 8'(i);
            e.data = w;
            e.last = (i == nwords - 1);
            exp_q.push_back(e);
            send_byte(w[15:8], stall);
            if (run_collide && i == 0) begin
                run_start = 1'b1;
                tick();
                run_start = 1'b0;
            end
            send_byte(w[7:0], stall);
        end
        wait_idle();
        check("load_no_pc_rst", pc_rst_cnt - pc0, 0);
        check("load_writes_drained", exp_q.size(), 0);
    endtask

    function automatic logic [15:0] rand_nonhalt();
        logic [3:0] op;
        op = 4'($urandom_range(0, 14));
        if (op >= 4'd6) op = op + 4'd1;
        return {op, 12'($urandom)};
    endfunction

    task automatic start_run();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        tick();
    endtask

    // n non-HALT instructions followed by HALT; expected commits are the
    // prefix length clipped by the watchdog.
    task automatic do_run(input int n);
        int en0;
        int pc0;
        int exp_cnt;
        bit done = 1'b0;
        en0 = cpu_en_cnt;
        pc0 = pc_rst_cnt;
        exp_cnt = (n < int'(LIMIT)) ? n : int'(LIMIT);
        start_run();
        for (int c = 0; c < 40 && !done; c++) begin
            fetch_instr = (c < n) ? rand_nonhalt() : {4'b0110, 12'($urandom)};
            tick();
            done = halted;
        end
        check("run_ended", done, 1);
        check("cpu_en_cycles", cpu_en_cnt - en0, exp_cnt);
        check("pc_rst_cycles", pc_rst_cnt - pc0, 1);
        check("instr_count", instr_count, exp_cnt);
        check("timeout", timeout, n >= int'(LIMIT));
        check("busy_after_run", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        rst         = 1'b1;
        load_start  = 1'b0;
        load_base   = 8'h00;
        load_len    = 8'h00;
        run_start   = 1'b0;
        abort       = 1'b0;
        fetch_instr = 16'h3100;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        tick();
        rst = 1'b0;

        // Fixed image, rx_valid never stalls.
        do_load(8'h00, 8'd3, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        // Address wrap 0xFE -> 0x00.
        do_load(8'hFE, 8'd2, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        // Length 0 means a full 256-word image.
        do_load(8'($urandom), 8'd0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        // load_start + run_start together, then run_start during LOAD_LO.
        do_load(8'($urandom), 8'd4, 1'b0, 1'b1, -1, 1'b1, 1'b1);
        // Abort after the high byte of word 2, then restart elsewhere.
        do_load(8'h10, 8'd4, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        check("abort_load_idle", busy, 0);
        do_load(8'h40, 8'd2, 1'b0, 1'b1, -1, 1'b0, 1'b0);

        // Runs: plain HALT, watchdog, timeout cleared, boundaries, random.
        do_run(5);
        do_run(20);
        repeat (3) tick();
        check("timeout_sticky", timeout, 1);
        do_run(3);
        do_run(int'(LIMIT));
        do_run(int'(LIMIT) - 1);
        do_run(0);
        for (int k = 0; k < 4; k++) do_run($urandom_range(0, 14));

        // Abort mid-run: no commit in the abort cycle, count holds.
        start_run();
        fetch_instr = 16'h3100;
        repeat (3) tick();
        abort = 1'b1;
        @(negedge clk);
        check("abort_cpu_en", cpu_en, 0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_run_count", instr_count, 3);
        check("abort_run_busy", busy, 0);
        check("abort_run_halted", halted, 0);
        tick();

        // Reset mid-run.
        start_run();
        fetch_instr = 16'h3100;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("reset_mid_run_outputs", all_outs(), 0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
- Controller for the 256 x 16-bit instruction memory and the single-cycle core's run state.
- Loads a program image into the memory from a byte stream (valid/ready), then starts the core, gates its PC advance, and stops it on HALT or watchdog timeout.
- Sits between the host/loader link, the instruction memory write port, and the core's PC/enable inputs.

Parameters:
- ADDR_W, 8, instruction memory address width (256 words).
- INSTR_W, 16, instruction width; must be 16 (two bytes per word).
- HALT_OP, 4'b0110, opcode in instr[15:12] that stops execution.
- WDOG_W, 16, width of the executed-instruction counter.
- WDOG_LIMIT, 16'hFFFF, executed-instruction count at which the run is force-stopped.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  pulse: begin program load.
- load_base  in  8  first word address of the load.
- load_len  in  8  number of words to load; 0 means 256.
- rx_data  in  8  loader byte, high byte of each word first.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  controller accepts rx_data this cycle.
- mem_we  out  1  instruction memory write enable.
- mem_waddr  out  8  write address.
- mem_wdata  out  16  write data.
- run_start  in  1  pulse: reset PC and run.
- abort  in  1  level: stop any load or run and return to IDLE.
- fetch_instr  in  16  instruction currently fetched by the core.
- pc_rst  out  1  one-cycle PC clear to the core.
- cpu_en  out  1  core commits the current instruction and advances PC.
- busy  out  1  state is not IDLE and not HALTED.
- halted  out  1  run ended (HALT or timeout).
- timeout  out  1  the last run ended on watchdog; sticky until the next run_start.
- load_done  out  1  one-cycle pulse after the last word is written.
- instr_count  out  16  instructions committed in the current or last run.

Behaviour:
- States: IDLE, LOAD_HI, LOAD_LO, WRITE, PC_CLR, RUN, HALTED.
- Reset (any state, including mid-load or mid-run):
  - State goes to IDLE.
  - All outputs 0, instr_count 0, internal address and remaining counters 0.
- IDLE / HALTED:
  - load_start: latch load_base into waddr and load_len into remaining (0 loads as 256, 9-bit count), then go to LOAD_HI.
  - run_start (without load_start): go to PC_CLR.
  - Both in the same cycle: load wins; run_start is dropped.
  - Leaving HALTED clears halted.
- LOAD_HI: rx_ready=1. On rx_valid&&rx_ready, capture rx_data into hi and go to LOAD_LO.
- LOAD_LO: rx_ready=1. On the handshake, capture lo and go to WRITE.
- WRITE:
  - rx_ready=0; mem_we=1 for exactly one cycle; mem_waddr=waddr; mem_wdata={hi,lo}.
  - Next cycle: waddr+1 (wraps 255->0, no error); remaining-1.
  - If remaining was 1: go to IDLE and pulse load_done; otherwise go to LOAD_HI.
- Load throughput: one word per 3 cycles minimum; rx_valid stalls extend LOAD_HI/LOAD_LO indefinitely.
- PC_CLR: pc_rst=1 for one cycle; instr_count cleared; timeout cleared. Next state is RUN.
- RUN, cpu_en is combinational:
  - cpu_en = (fetch_instr[15:12] != HALT_OP) && (instr_count != WDOG_LIMIT).
  - Each cycle with cpu_en=1: instr_count+1.
  - fetch_instr opcode == HALT_OP: cpu_en=0 in that cycle, so HALT is never committed; go to HALTED and leave the PC on the HALT address.
  - instr_count == WDOG_LIMIT: cpu_en=0, timeout<=1, go to HALTED.
  - HALT and limit in the same cycle: HALTED with timeout=1.
- HALTED: halted=1, cpu_en=0; instr_count holds.
- abort:
  - Highest priority after rst: next state is IDLE.
  - mem_we and cpu_en are forced 0 in the abort cycle, and a partially assembled word is discarded.
  - halted, timeout and instr_count hold.
- load_start and run_start are ignored in every state except IDLE and HALTED.
- mem_we, rx_ready and cpu_en are never asserted in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants (JMP=0000, LOAD=0001, STORE=0010, ADD=0011, SUB=0100, ADDI=0101, HALT=0110, AND=0111).
  - The ADDR_W and INSTR_W constants.
  - The imem_ctrl state enum.
- No sub-module: byte assembly, address counter and watchdog are each a few registers inside imem_ctrl.

Test Plan:
- Load: load_base=0, load_len=3, bytes 50 05 51 0A 60 00 with rx_valid always 1 -> three mem_we pulses at addr 0,1,2 with data 0x5005, 0x510A, 0x6000; load_done 1 cycle after the third write; rx_ready low during each WRITE.
- Wrap and len=0:
  - load_base=0xFE, load_len=2 -> writes at 0xFE then 0x00.
  - load_len=0 with 512 bytes -> exactly 256 writes, then load_done.
- Run to HALT: drive fetch_instr as non-HALT for 5 cycles, then 0x6006 -> pc_rst 1 cycle, cpu_en high for 5 cycles, low on the HALT cycle; halted=1, instr_count=5, timeout=0.
- Watchdog: WDOG_LIMIT=10 with fetch_instr always 0x3100 -> cpu_en high for exactly 10 cycles, then halted=1, timeout=1, instr_count=10; a subsequent run_start clears timeout.
- Abort and reset mid-load:
  - abort after the high byte of word 2 -> no second mem_we; state IDLE; a new load_start restarts at the new load_base.
  - rst during RUN -> all outputs 0 the next cycle.
- Collisions: load_start and run_start in the same IDLE cycle -> load proceeds and no pc_rst; run_start during LOAD_LO -> ignored.
